// File: rtl/avg_frame_ctrl.sv
// avg_frame_ctrl: sequencer for the 8-lane adder-tree averaging datapath.
// Walks the sample memory, feeds the tree, waits out its pipeline, then
// presents sum >> SHIFT behind a valid/ready handshake.
// Optional macro AVG_ROUND_EN: round to nearest (add 2^(SHIFT-1) before the
// shift); when undefined the average is truncated. Timing is identical.
module avg_frame_ctrl #(
  parameter int unsigned BEATS    = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned TREE_LAT = 3,
  parameter int unsigned SHIFT    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              tree_clr,
  output logic              tree_in_valid,
  input  logic [31:0]       tree_sum,
  output logic [31:0]       result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              aborted
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_STREAM, S_DRAIN, S_ROUND, S_HOLD
  } state_t;

  // Drain counter counts 0..TREE_LAT (TREE_LAT+1 cycles: tree latency plus
  // the one-cycle memory read latency ahead of tree_in_valid).
  localparam int unsigned DW = $clog2(TREE_LAT + 2);
  localparam logic [ADDR_W-1:0] LAST_BEAT  = ADDR_W'(BEATS - 1);
  localparam logic [DW-1:0]     LAST_DRAIN = DW'(TREE_LAT);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   beat_q, beat_d;
  logic [DW-1:0]       drain_q, drain_d;
  logic [31:0]         result_q, result_d;
  logic                tv_q, tv_d;
  logic                aborted_q, aborted_d;
  logic                kill;
  logic [32:0]         sum_ext;
  logic [31:0]         avg;

  // 33-bit sum so the rounding bias can never overflow.
`ifdef AVG_ROUND_EN
  assign sum_ext = {1'b0, tree_sum} + (33'd1 << (SHIFT - 1));
`else
  assign sum_ext = {1'b0, tree_sum};
`endif
  assign avg = 32'(sum_ext >> SHIFT);

  // abort only cancels frames that have not yet captured a result.
  assign kill = abort && (state_q == S_CLEAR || state_q == S_STREAM ||
                          state_q == S_DRAIN);

  // Next-state, counters and result capture.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    drain_d   = drain_q;
    result_d  = result_q;
    aborted_d = 1'b0;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CLEAR;
      S_CLEAR: state_d = S_STREAM;
      S_STREAM: begin
        if (beat_q == LAST_BEAT) begin
          beat_d  = '0;
          state_d = S_DRAIN;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == LAST_DRAIN) begin
          drain_d = '0;
          state_d = S_ROUND;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      S_ROUND: begin
        result_d = avg;
        state_d  = S_HOLD;
      end
      S_HOLD:  if (result_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Cancel overrides everything, including the final STREAM beat.
    if (kill) begin
      state_d   = S_IDLE;
      beat_d    = '0;
      drain_d   = '0;
      aborted_d = 1'b1;
    end
  end

  // Read-valid delay flop tracks the memory's one-cycle read latency.
  assign tv_d = mem_rd_en && !kill;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      beat_q    <= '0;
      drain_q   <= '0;
      result_q  <= '0;
      tv_q      <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      drain_q   <= drain_d;
      result_q  <= result_d;
      tv_q      <= tv_d;
      aborted_q <= aborted_d;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign mem_rd_en     = (state_q == S_STREAM);
  assign mem_addr      = beat_q;
  assign tree_clr      = (state_q == S_CLEAR);
  assign tree_in_valid = tv_q;
  assign result        = result_q;
  assign result_valid  = (state_q == S_HOLD);
  assign aborted       = aborted_q;

endmodule

// File: tb/tb_avg_frame_ctrl.sv
// Bench for avg_frame_ctrl: behavioural sample memory and 3-stage adder tree,
// table-driven frames plus hold, abort and async-reset sequences.
module tb_avg_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, abort, result_ready;
  logic        busy, mem_rd_en, tree_clr, tree_in_valid, result_valid, aborted;
  logic [4:0]  mem_addr;
  logic [31:0] tree_sum, result;

  always #5 clk = ~clk;

  avg_frame_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .tree_clr(tree_clr),
    .tree_in_valid(tree_in_valid), .tree_sum(tree_sum), .result(result),
    .result_valid(result_valid), .result_ready(result_ready), .aborted(aborted)
  );

  // Sample memory (8 byte lanes) with 1-cycle read latency.
  logic [63:0] mem [32];
  logic [63:0] rdata = '0;
  // Adder tree: beat sampled at edge e is in acc after edge e+3.
  logic [31:0] d1 = '0, d2 = '0, d3 = '0, acc = '0;

  function automatic logic [31:0] lsum(input logic [63:0] w);
    logic [31:0] s;
    s = '0;
    for (int k = 0; k < 8; k++) s += 32'(w[k*8 +: 8]);
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (mem_rd_en) rdata <= mem[mem_addr];
    if (tree_clr) begin
      d1 <= '0; d2 <= '0; d3 <= '0; acc <= '0;
    end else begin
      d1  <= tree_in_valid ? lsum(rdata) : 32'd0;
      d2  <= d1;
      d3  <= d2;
      acc <= acc + d3;
    end
  end
  assign tree_sum = acc;

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0] fill;
    logic [63:0] first;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic load_mem(input logic [63:0] fill, input logic [63:0] first);
    for (int i = 0; i < 32; i++) mem[i] = fill;
    mem[0] = first;
  endtask

  // Pulse start, follow the frame to result_valid and check its shape.
  task automatic run_frame(input logic [31:0] exp);
    int cyc, naddr, nclr;
    logic gap_ok, clr_first, tv_seen;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0; naddr = 0; nclr = 0; gap_ok = 1'b1; clr_first = 1'b1; tv_seen = 1'b0;
    while (cyc < 200) begin
      @(negedge clk); cyc++;
      if (tree_clr) begin nclr++; if (tv_seen) clr_first = 1'b0; end
      if (tree_in_valid) tv_seen = 1'b1;
      if (mem_rd_en) begin
        if (mem_addr != 5'(naddr)) gap_ok = 1'b0;
        naddr++;
      end
      if (result_valid) break;
    end
    chk("valid_latency", 32'(cyc), 32'd39);
    chk("addr_count", 32'(naddr), 32'd32);
    chk("addr_seq", 32'(gap_ok), 32'd1);
    chk("clr_once", 32'(nclr), 32'd1);
    chk("clr_before_valid", 32'(clr_first), 32'd1);
    chk("result", result, exp);
  endtask

  // Accept the held result; optionally raise start in the same cycle.
  task automatic accept(input logic with_start);
    @(negedge clk); result_ready = 1'b1; start = with_start;
    @(negedge clk); result_ready = 1'b0; start = 1'b0;
    chk("accept_valid_low", 32'(result_valid), 32'd0);
    chk("accept_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    logic [31:0] r384, r248, last_exp;
    logic ok, found;
    int na, nv;
`ifdef AVG_ROUND_EN
    r384 = 32'd2; r248 = 32'd1;
`else
    r384 = 32'd1; r248 = 32'd0;
`endif
    vecs[0] = '{64'h0101010101010101, 64'h0101010101010101, 32'd1};
    vecs[1] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 32'd255};
    vecs[2] = '{64'h000000000000000C, 64'h000000000000000C, r384};
    vecs[3] = '{64'h000000000000000C, 64'h000000000000000B, 32'd1};
    vecs[4] = '{64'h0000000000000000, 64'h0000000000000000, 32'd0};
    vecs[5] = '{64'h8080808080808080, 64'h8080808080808080, 32'd128};
    vecs[6] = '{64'h0101010101010101, 64'h0000000000000000, r248};

    rst = 1'b1; start = 1'b0; abort = 1'b0; result_ready = 1'b0;
    load_mem('0, '0);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_strobes", 32'({mem_rd_en, tree_clr, tree_in_valid, result_valid, aborted}), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      load_mem(vecs[i].fill, vecs[i].first);
      run_frame(vecs[i].exp);
      accept(1'b0);
    end

    // Hold in HOLD for 20 cycles with stray start/abort pulses.
    load_mem(vecs[2].fill, vecs[2].first);
    run_frame(vecs[2].exp);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (result !== vecs[2].exp || !result_valid || !busy || mem_rd_en || aborted) ok = 1'b0;
      start = (i == 10);
      abort = (i == 5);
    end
    start = 1'b0; abort = 1'b0;
    chk("hold_stable", 32'(ok), 32'd1);
    accept(1'b1);
    repeat (3) @(negedge clk);
    chk("stray_start_ignored", 32'(busy), 32'd0);
    last_exp = vecs[2].exp;

    // Abort at beat 10.
    load_mem(vecs[1].fill, vecs[1].first);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_rd_en && mem_addr == 5'd10) begin found = 1'b1; break; end
    end
    chk("abort_reached_beat10", 32'(found), 32'd1);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    chk("abort_rd_low", 32'(mem_rd_en), 32'd0);
    chk("abort_pulse", 32'(aborted), 32'd1);
    chk("abort_tv_low", 32'(tree_in_valid), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);
    chk("abort_result_kept", result, last_exp);
    na = 0; nv = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (aborted) na++;
      if (result_valid) nv++;
    end
    chk("abort_single_pulse", 32'(na), 32'd0);
    chk("abort_no_valid", 32'(nv), 32'd0);
    run_frame(32'd255);
    accept(1'b0);

    // Asynchronous reset in the middle of DRAIN (cycle 35).
    load_mem(vecs[5].fill, vecs[5].first);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (35) @(negedge clk);
    chk("pre_reset_draining", 32'({busy, mem_rd_en, result_valid}), 32'b100);
    #2 rst = 1'b1;
    #1;
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_result", result, 32'd0);
    chk("async_strobes", 32'({mem_rd_en, tree_clr, tree_in_valid, result_valid, aborted}), 32'd0);
    chk("async_addr", 32'(mem_addr), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", 32'(busy), 32'd0);
    run_frame(32'd128);
    accept(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
